// File: rtl/booth_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_div_pkg
// Description : Shared types and helpers for the sequential signed divider.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int MAX_WIDTH = 32;
    // Wide enough to hold an iteration count of WIDTH for any legal WIDTH.
    localparam int CNT_W     = $clog2(MAX_WIDTH + 1);

    // Operands arrive sign-extended to MAX_WIDTH; callers truncate the result.
    function automatic logic [MAX_WIDTH-1:0] abs_val(input logic [MAX_WIDTH-1:0] v);
        return v[MAX_WIDTH-1] ? -v : v;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] cond_neg(input logic [MAX_WIDTH-1:0] v,
                                                      input logic                 neg);
        return neg ? -v : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_divider_seq_step.sv
`default_nettype none
// ============================================================================
// Module      : div_restore_step
// Description : One combinational restoring-division iteration on magnitudes.
// Revision    : 1.0 - initial release
// ============================================================================
module div_restore_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH+1:0] w_a_sh;
    logic [WIDTH+1:0] w_trial;
    logic             w_fit;

    // One guard bit above A so the trial sign is never lost on the shift.
    assign w_a_sh  = {a_i, q_i[WIDTH-1]};
    assign w_trial = w_a_sh - {2'b00, d_i};
    assign w_fit   = ~w_trial[WIDTH+1];

    assign a_o = w_fit ? w_trial[WIDTH:0] : w_a_sh[WIDTH:0];
    assign q_o = {q_i[WIDTH-2:0], w_fit};

endmodule
`default_nettype wire

// File: rtl/booth_divider_seq.sv
`default_nettype none
// ============================================================================
// Module      : booth_divider_seq
// Description : Sequential signed restoring divider with start/done handshake.
//               Optional macro DIVIDER_OVF_DETECT_EN short-cuts MIN / -1.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_divider_seq
    import booth_div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             ovf
);

    div_state_e       state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] qr_q, qr_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
`ifdef DIVIDER_OVF_DETECT_EN
    localparam logic [WIDTH-1:0] c_most_neg = {1'b1, {(WIDTH-1){1'b0}}};
    logic             ovf_q, ovf_d;
`endif

    logic [WIDTH:0]   w_step_a;
    logic [WIDTH-1:0] w_step_q;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .a_i (a_q),
        .q_i (qr_q),
        .d_i (dvs_q),
        .a_o (w_step_a),
        .q_o (w_step_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            qr_q    <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef DIVIDER_OVF_DETECT_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            qr_q    <= qr_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
`ifdef DIVIDER_OVF_DETECT_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        qr_d    = qr_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef DIVIDER_OVF_DETECT_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dbz_d = 1'b0;
`ifdef DIVIDER_OVF_DETECT_EN
                    ovf_d = 1'b0;
`endif
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end
`ifdef DIVIDER_OVF_DETECT_EN
                    else if (dividend == c_most_neg && divisor == '1) begin
                        state_d = DONE;
                        quot_d  = dividend;
                        rem_d   = '0;
                        ovf_d   = 1'b1;
                    end
`endif
                    else begin
                        // Magnitude of MIN fits as an unsigned WIDTH-bit value.
                        a_d     = '0;
                        qr_d    = WIDTH'(abs_val(MAX_WIDTH'(signed'(dividend))));
                        dvs_d   = WIDTH'(abs_val(MAX_WIDTH'(signed'(divisor))));
                        negq_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        negr_d  = dividend[WIDTH-1];
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                a_d   = w_step_a;
                qr_d  = w_step_q;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quot_d  = WIDTH'(cond_neg(MAX_WIDTH'(qr_q), negq_q));
                rem_d   = WIDTH'(cond_neg(MAX_WIDTH'(a_q[WIDTH-1:0]), negr_q));
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q == ITER) || (state_q == FIX);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
`ifdef DIVIDER_OVF_DETECT_EN
    assign ovf         = ovf_q;
`else
    assign ovf         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_booth_divider_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_booth_divider_seq
// Description : Randomised scoreboard bench for booth_divider_seq (WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_divider_seq;

    localparam int W = 4;
`ifdef DIVIDER_OVF_DETECT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, dz, ov;
    logic [W-1:0] quot, rem;

    logic [W:0]   st_a, st_ao;
    logic [W-1:0] st_q, st_d, st_qo;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           dz;
        bit           ov;
        int           lat;
        int           start_edge;
    } exp_t;

    exp_t         scb[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           n;
    bit           have_last = 1'b1;
    logic [W-1:0] last_q = '0, last_r = '0;
    bit           last_dz = 1'b0, last_ov = 1'b0;

    booth_divider_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quot),
        .remainder   (rem),
        .div_by_zero (dz),
        .ovf         (ov)
    );

    div_restore_step #(.WIDTH(W)) u_step (
        .a_i (st_a),
        .q_i (st_q),
        .d_i (st_d),
        .a_o (st_ao),
        .q_o (st_qo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain signed integer division (truncating) plus the special cases.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t               e;
        logic signed [W-1:0] ta, tb;
        int                 sa, sbv, qi, ri;
        logic [31:0]        tq, tr;
        ta = a;
        tb = b;
        sa = ta;
        sbv = tb;
        e.dz = 1'b0;
        e.ov = 1'b0;
        e.lat = W + 2;
        e.start_edge = 0;
        if (sbv == 0) begin
            e.q = '1;
            e.r = a;
            e.dz = 1'b1;
            e.lat = 1;
        end else begin
            qi = sa / sbv;
            ri = sa % sbv;
            tq = qi;
            tr = ri;
            e.q = tq[W-1:0];
            e.r = tr[W-1:0];
            if (OVF_EN && sa == -(1 << (W-1)) && sbv == -1) begin
                e.ov = 1'b1;
                e.lat = 1;
            end
        end
        return e;
    endfunction

    task automatic pin(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input int elat);
        exp_t e;
        e = model(a, b);
        chk("model_quotient", e.q, eq);
        chk("model_remainder", e.r, er);
        chk("model_latency", e.lat, elat);
    endtask

    // Single compare process: timing, handshake and results on every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            chk("reset_outputs", {busy, done, dz, ov, quot, rem}, 32'd0);
        end else if (scb.size() > 0 && cyc >= scb[0].start_edge) begin
            n = cyc - scb[0].start_edge + 1;
            chk("busy", busy, (scb[0].lat > 1 && n <= W + 1));
            if (done) begin
                chk("latency", n, scb[0].lat);
                chk("quotient", quot, scb[0].q);
                chk("remainder", rem, scb[0].r);
                chk("div_by_zero", dz, scb[0].dz);
                chk("ovf", ov, scb[0].ov);
                last_q = scb[0].q;
                last_r = scb[0].r;
                last_dz = scb[0].dz;
                last_ov = scb[0].ov;
                have_last = 1'b1;
                void'(scb.pop_front());
            end else if (n >= scb[0].lat) begin
                chk("done_missing", done, 1'b1);
                void'(scb.pop_front());
            end
        end else if (scb.size() == 0) begin
            chk("idle_busy_done", {busy, done}, 32'd0);
            if (have_last)
                chk("held_results", {dz, ov, quot, rem}, {last_dz, last_ov, last_q, last_r});
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int lead, input bit track);
        exp_t e;
        start = 1'b1;
        dividend = a;
        divisor = b;
        if (track) begin
            e = model(a, b);
            e.start_edge = cyc + lead;
            scb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (scb.size() != 0 && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (scb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: %0d operations still pending, expected 0", scb.size());
            scb.delete();
        end
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        #1;
        issue(a, b, 1, 1'b1);
        @(negedge clk);
        #1;
        start = 1'b0;
        dividend = W'($urandom);
        divisor = W'($urandom);
        wait_idle();
    endtask

    initial begin
        int ea, eq, rm, bitv;
        // Reference model pinned against hand-computed values.
        pin(4'd7, 4'd2, 4'b0011, 4'b0001, 6);
        pin(4'b1001, 4'd2, 4'b1101, 4'b1111, 6);
        pin(4'd7, 4'b1110, 4'b1101, 4'b0001, 6);
        pin(4'b1010, 4'b1110, 4'b0011, 4'b0000, 6);
        pin(4'd5, 4'd0, 4'b1111, 4'b0101, 1);
        pin(4'b1000, 4'b1111, 4'b1000, 4'b0000, OVF_EN ? 1 : 6);

        // Stand-alone iteration step against integer long-division arithmetic.
        for (int i = 0; i < 24; i++) begin
            st_d = W'($urandom_range(1, 1 << (W-1)));
            st_a = (W+1)'($urandom_range(0, int'(st_d) - 1));
            st_q = W'($urandom);
            #1;
            rm = 2 * int'(st_a) + int'(st_q[W-1]);
            bitv = (rm >= int'(st_d)) ? 1 : 0;
            ea = (bitv == 1) ? rm - int'(st_d) : rm;
            eq = ((int'(st_q) << 1) | bitv) & ((1 << W) - 1);
            chk("step_a", st_ao, ea);
            chk("step_q", st_qo, eq);
        end

        repeat (3) @(negedge clk);
        #1;
        reset = 1'b1;

        run(4'd7, 4'd2);
        run(4'b1001, 4'd2);
        run(4'd7, 4'b1110);
        run(4'b1010, 4'b1110);
        run(4'd5, 4'd0);
        run(4'b1000, 4'b1111);
        run(4'b1000, 4'd1);
        run(4'b0111, 4'b1000);

        // Request while busy must be ignored.
        @(negedge clk);
        #1;
        issue(4'd6, 4'd2, 1, 1'b1);
        @(negedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        #1;
        issue(4'd7, 4'd3, 1, 1'b0);
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Start held high: next operation accepted in the IDLE cycle after done.
        for (int j = 0; j < 4; j++) begin
            int k;
            @(negedge clk);
            #1;
            issue(W'($urandom), (j == 1) ? 4'd0 : W'($urandom_range(1, 15)), 1, 1'b1);
            k = 0;
            while (scb.size() != 0 && k < 40) begin
                @(negedge clk);
                #1;
                k++;
            end
            issue(W'($urandom), W'($urandom_range(1, 15)), 2, 1'b1);
            @(negedge clk);
            #1;
            @(negedge clk);
            #1;
            start = 1'b0;
            wait_idle();
        end

        // Reset during the third ITER cycle aborts without a done pulse.
        @(negedge clk);
        #1;
        issue(4'd7, 4'd2, 1, 1'b1);
        @(negedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        scb.delete();
        last_q = '0;
        last_r = '0;
        last_dz = 1'b0;
        last_ov = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        run(4'd3, 4'd2);

        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] a, b;
            a = ($urandom_range(0, 9) == 0) ? 4'b1000 : W'($urandom);
            case ($urandom_range(0, 9))
                0:       b = 4'd0;
                1:       b = 4'b1111;
                default: b = W'($urandom);
            endcase
            run(a, b);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/booth_divider_seq.md
Name: booth_divider_seq

Overview:
- Sequential signed two's-complement divider; the inverse of the team's sequential Booth multiplier, sitting beside it in the arithmetic datapath.
- Algorithm: restoring shift/subtract on operand magnitudes, one quotient bit per clock, then a single sign-correction step.
- Interface: start/done handshake.
- Results: quotient truncated toward zero; remainder takes the sign of the dividend.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2 to 32).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- dividend  in  WIDTH  signed dividend; captured on the accepted start.
- divisor  in  WIDTH  signed divisor; captured on the accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; results valid in that cycle.
- quotient  out  WIDTH  signed quotient; held until the next accepted start.
- remainder  out  WIDTH  signed remainder; held until the next accepted start.
- div_by_zero  out  1  qualified by done.
- ovf  out  1  qualified by done; see Optional Feature.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; busy, done, div_by_zero and ovf = 0; quotient and remainder = 0; internal registers = 0, iteration counter = 0.
- States: IDLE, ITER, FIX, DONE.
- IDLE, start=1, divisor!=0 at edge k:
  - latch |dividend| into Q and |divisor| into D; clear partial remainder A (WIDTH+1 bits).
  - latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - set count=WIDTH; go to ITER.
- IDLE, start=1, divisor==0: go directly to DONE. Outputs: quotient = all ones, remainder = dividend, div_by_zero=1. done is therefore high in the cycle after edge k.
- ITER, one edge per iteration:
  - {A,Q} shifted left by 1, then trial T = A - D.
  - If T >= 0: A=T and Q[0]=1. Otherwise A is unchanged and Q[0]=0.
  - count decrements; exit to FIX when count reaches 0, giving exactly WIDTH ITER cycles.
- FIX (one edge):
  - quotient = sign_q ? -Q : Q.
  - remainder = sign_r ? -A[WIDTH-1:0] : A[WIDTH-1:0].
  - go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE. Normal-path done latency is WIDTH+2 edges after the start edge.
- Magnitude of the most-negative dividend is handled as an unsigned WIDTH-bit value. It must not be sign-extended incorrectly.
- busy=1 in ITER and FIX only.
- start while busy or in DONE: ignored; operands are not re-sampled.
- start held high continuously: a new operation is accepted in the IDLE cycle following done (back-to-back).
- Operand inputs may change freely after the accepted start edge.
- Reset asserted mid-operation: immediate return to reset values. No done pulse is produced for the aborted operation.
- Results and flags hold their values after done until the next accepted start. div_by_zero and ovf are cleared when the next start is accepted.

Optional Feature:
- Macro: DIVIDER_OVF_DETECT_EN.
- Defined: in IDLE, dividend == -2^(WIDTH-1) together with divisor == -1 takes the DONE shortcut. Outputs: quotient = -2^(WIDTH-1) (the wrapped value), remainder = 0, ovf=1, done one cycle after start.
- Undefined: ovf is tied to 0. That operand case runs the normal iterative path and yields the same quotient and remainder, with WIDTH+2 latency.

Decomposition:
- Shared package booth_div_pkg holds:
  - state enum (IDLE, ITER, FIX, DONE);
  - localparam for the counter width, $clog2(WIDTH+1);
  - function for two's-complement absolute value;
  - function for conditional negate.
- Natural sub-module: div_restore_step, a combinational single iteration. Inputs A, Q, D; outputs next A and next Q. It is reused by the FSM and unit-tested on its own.

Test Plan (WIDTH=4):
- 7/2: done after 6 edges; quotient 0011, remainder 0001; div_by_zero=0, ovf=0.
- -7/2: quotient 1101 (-3), remainder 1111 (-1). 7/-2: quotient 1101, remainder 0001. -6/-2: quotient 0011, remainder 0000.
- 5/0: done 1 cycle after start; div_by_zero=1, quotient 1111, remainder 0101, busy never asserted.
- -8/-1: quotient 1000, remainder 0000. With DIVIDER_OVF_DETECT_EN: ovf=1, done after 1 cycle. Without it: ovf=0, done after 6 cycles.
- Pulse start=1 with 7/3 while busy during 6/2: the second request is ignored; result is quotient 0011, remainder 0000.
- Assert reset during the third ITER cycle of 7/2: all outputs 0 and no done pulse. A following 3/2 yields quotient 0001, remainder 0001.
